iobus_initiator: RTL and testbench

Bus-master end of the MicroBlaze MCS style IO bus: turns single read/write commands into IO bus transactions (address/read/write strobes, byte enables, write data) and returns read data or a timeout error. It sits in front of an IO bus multiplexer in place of, or alongside, the MCS core. Bench traffic generators and future DMA engines use it to drive the SDRAM controller and PRNG peripherals without a processor.

---
 rtl/iobus_initiator.sv | 126 ++++++++++++
 tb/tb_iobus_initiator.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/iobus_initiator.sv
// rtl/iobus_initiator.sv - IO bus master turning single read/write commands into strobed bus transactions
module iobus_initiator #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        io_clk,
  input  logic        io_rst_n,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_write,
  input  logic [31:0] cmd_address,
  input  logic [3:0]  cmd_byte_enable,
  input  logic [31:0] cmd_write_data,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_read_data,
  output logic        rsp_error,
  output logic        busy,
  output logic        io_addr_strobe,
  output logic        io_read_strobe,
  output logic        io_write_strobe,
  output logic [31:0] io_address,
  output logic [3:0]  io_byte_enable,
  output logic [31:0] io_write_data,
  input  logic [31:0] io_read_data,
  input  logic        io_ready
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

  typedef enum logic [1:0] {
    S_IDLE,
    S_STROBE,
    S_WAIT,
    S_RESP
  } state_t;

  state_t           state_q, state_nxt;
  logic             write_q;
  logic [CNT_W-1:0] cnt_q;
  logic             timeout_hit;

  // The final WAIT cycle is the one in which the counter would reach TIMEOUT_CYCLES.
  assign timeout_hit = (cnt_q == CNT_LAST);

  always_ff @(posedge io_clk or negedge io_rst_n) begin
    if (!io_rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_nxt;
    end
  end

  always_comb begin
    state_nxt       = state_q;
    cmd_ready       = 1'b0;
    busy            = 1'b1;
    rsp_valid       = 1'b0;
    io_addr_strobe  = 1'b0;
    io_read_strobe  = 1'b0;
    io_write_strobe = 1'b0;
    case (state_q)
      S_IDLE: begin
        cmd_ready = 1'b1;
        busy      = 1'b0;
        if (cmd_valid) begin
          state_nxt = S_STROBE;
        end
      end
      S_STROBE: begin
        io_addr_strobe  = 1'b1;
        io_read_strobe  = ~write_q;
        io_write_strobe = write_q;
        state_nxt       = S_WAIT;
      end
      S_WAIT: begin
        if (io_ready || timeout_hit) begin
          state_nxt = S_RESP;
        end
      end
      S_RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) begin
          state_nxt = S_IDLE;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge io_clk or negedge io_rst_n) begin
    if (!io_rst_n) begin
      write_q        <= 1'b0;
      io_address     <= '0;
      io_byte_enable <= '0;
      io_write_data  <= '0;
      cnt_q          <= '0;
      rsp_read_data  <= '0;
      rsp_error      <= 1'b0;
    end else begin
      if (state_q == S_IDLE && cmd_valid) begin
        write_q        <= cmd_write;
        io_address     <= cmd_address;
        io_byte_enable <= cmd_byte_enable;
        io_write_data  <= cmd_write_data;
      end
      if (state_q == S_STROBE) begin
        cnt_q <= '0;
      end else if (state_q == S_WAIT && !io_ready && cnt_q != CNT_MAX) begin
        cnt_q <= cnt_q + 1'b1;
      end
      // A ready arriving on the last counted cycle still completes normally.
      if (state_q == S_WAIT) begin
        if (io_ready) begin
          rsp_read_data <= write_q ? 32'h0 : io_read_data;
          rsp_error     <= 1'b0;
        end else if (timeout_hit) begin
          rsp_read_data <= 32'h0;
          rsp_error     <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_iobus_initiator.sv
// tb/tb_iobus_initiator.sv - self-checking bench for iobus_initiator
module tb_iobus_initiator;

  localparam int T = 8;

  logic        io_clk = 1'b0;
  logic        io_rst_n;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_write;
  logic [31:0] cmd_address;
  logic [3:0]  cmd_byte_enable;
  logic [31:0] cmd_write_data;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_read_data;
  logic        rsp_error;
  logic        busy;
  logic        io_addr_strobe;
  logic        io_read_strobe;
  logic        io_write_strobe;
  logic [31:0] io_address;
  logic [3:0]  io_byte_enable;
  logic [31:0] io_write_data;
  logic [31:0] io_read_data;
  logic        io_ready;

  int tests = 0;
  int fails = 0;

  iobus_initiator #(.TIMEOUT_CYCLES(T)) dut (
    .io_clk(io_clk), .io_rst_n(io_rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_address(cmd_address), .cmd_byte_enable(cmd_byte_enable),
    .cmd_write_data(cmd_write_data),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_read_data(rsp_read_data),
    .rsp_error(rsp_error), .busy(busy),
    .io_addr_strobe(io_addr_strobe), .io_read_strobe(io_read_strobe),
    .io_write_strobe(io_write_strobe), .io_address(io_address),
    .io_byte_enable(io_byte_enable), .io_write_data(io_write_data),
    .io_read_data(io_read_data), .io_ready(io_ready)
  );

  always #5 io_clk = ~io_clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference: a response follows the first honoured ready (cycles 2..T+1) by one cycle,
  // otherwise the timeout response appears in cycle T+2.
  task automatic model(input logic wr, input int rdy, input logic [31:0] rd,
                       output logic err, output logic [31:0] data, output int cyc);
    if (rdy >= 2 && rdy <= T + 1) begin
      cyc = rdy + 1; err = 1'b0; data = wr ? 32'h0 : rd;
    end else begin
      cyc = T + 2; err = 1'b1; data = 32'h0;
    end
  endtask

  task automatic run_txn(input string nm, input logic wr, input logic [31:0] addr,
                         input logic [3:0] be, input logic [31:0] wd,
                         input int rdy_cyc, input int stray_cyc, input logic [31:0] rd,
                         input int hold, input logic late_rdy,
                         input logic exp_err, input logic [31:0] exp_rd, input int exp_cyc);
    int rsp_cyc = -1;
    int stb_err = 0;
    int bus_err = 0;
    int hold_err = 0;
    logic [31:0] d0;
    logic e0;
    @(negedge io_clk);
    io_ready = 1'b0;
    chk({nm, "_cmd_ready"}, {31'h0, cmd_ready}, 32'h1);
    cmd_valid = 1'b1; cmd_write = wr; cmd_address = addr;
    cmd_byte_enable = be; cmd_write_data = wd; rsp_ready = 1'b0;
    for (int c = 1; c <= 40 && rsp_cyc < 0; c++) begin
      @(negedge io_clk);
      cmd_valid = 1'b0; cmd_write = $urandom; cmd_address = $urandom;
      cmd_byte_enable = 4'($urandom); cmd_write_data = $urandom;
      if (c == 1) begin
        if (!(io_addr_strobe && io_read_strobe == !wr && io_write_strobe == wr)) stb_err++;
      end else if (io_addr_strobe || io_read_strobe || io_write_strobe) begin
        stb_err++;
      end
      if (io_address !== addr || io_byte_enable !== be || io_write_data !== wd) bus_err++;
      if (rsp_valid) rsp_cyc = c;
      io_ready = (c == rdy_cyc) || (c == stray_cyc);
      io_read_data = (c == rdy_cyc) ? rd : $urandom;
    end
    chk({nm, "_strobes"}, stb_err, 0);
    chk({nm, "_bus_hold"}, bus_err, 0);
    chk({nm, "_rsp_cycle"}, rsp_cyc, exp_cyc);
    chk({nm, "_rsp_error"}, {31'h0, rsp_error}, {31'h0, exp_err});
    chk({nm, "_rsp_data"}, rsp_read_data, exp_rd);
    d0 = rsp_read_data; e0 = rsp_error;
    io_ready = late_rdy;
    for (int h = 0; h < hold; h++) begin
      @(negedge io_clk);
      if (!rsp_valid || cmd_ready || rsp_read_data !== d0 || rsp_error !== e0) hold_err++;
    end
    if (hold > 0) chk({nm, "_backpressure"}, hold_err, 0);
    rsp_ready = 1'b1;
    @(negedge io_clk);
    rsp_ready = 1'b0;
    chk({nm, "_release"}, {29'h0, cmd_ready, rsp_valid, busy}, 32'h4);
    io_ready = 1'b0;
  endtask

  typedef struct {
    logic        wr;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wd;
    int          rdy;
    int          stray;
    logic [31:0] rd;
    int          hold;
    logic        late;
    logic        exp_err;
    logic [31:0] exp_rd;
    int          exp_cyc;
  } vec_t;

  vec_t vecs[9];

  initial begin
    int rsp_seen;
    logic        r_wr, m_err;
    logic [31:0] m_data, r_rd;
    int          r_rdy, m_cyc;

    vecs[0] = '{1'b1, 32'hC0000004, 4'hF, 32'h12345678, 2, 0, 32'hDEADBEEF, 0, 1'b0, 1'b0, 32'h0, 3};
    vecs[1] = '{1'b0, 32'hE0000010, 4'hF, 32'h0, 6, 0, 32'hA5A5F00D, 0, 1'b0, 1'b0, 32'hA5A5F00D, 7};
    vecs[2] = '{1'b0, 32'hE0000020, 4'hF, 32'h0, 0, 0, 32'h11111111, 2, 1'b1, 1'b1, 32'h0, 10};
    vecs[3] = '{1'b0, 32'hE0000024, 4'hF, 32'h0, 3, 0, 32'h13572468, 0, 1'b0, 1'b0, 32'h13572468, 4};
    vecs[4] = '{1'b1, 32'hC0000100, 4'h5, 32'h55AA55AA, 2, 0, 32'h0, 10, 1'b0, 1'b0, 32'h0, 3};
    vecs[5] = '{1'b0, 32'hE0000030, 4'hF, 32'h0, 9, 0, 32'hCAFEF00D, 0, 1'b0, 1'b0, 32'hCAFEF00D, 10};
    vecs[6] = '{1'b0, 32'hE0000034, 4'hF, 32'h0, 10, 0, 32'h22222222, 0, 1'b0, 1'b1, 32'h0, 10};
    vecs[7] = '{1'b0, 32'hE0000040, 4'hF, 32'h0, 4, 1, 32'h0BADBEEF, 0, 1'b0, 1'b0, 32'h0BADBEEF, 5};
    vecs[8] = '{1'b1, 32'hC0000008, 4'h3, 32'h0000BEEF, 9, 0, 32'h33333333, 1, 1'b0, 1'b0, 32'h0, 10};

    io_rst_n = 1'b0; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_address = '0;
    cmd_byte_enable = '0; cmd_write_data = '0; rsp_ready = 1'b0;
    io_read_data = '0; io_ready = 1'b0;
    repeat (3) @(negedge io_clk);
    chk("reset_ctrl", {26'h0, rsp_valid, rsp_error, busy, io_addr_strobe, io_read_strobe, io_write_strobe}, 32'h0);
    chk("reset_addr", io_address, 32'h0);
    chk("reset_wdata", io_write_data, 32'h0);
    chk("reset_rdata", rsp_read_data, 32'h0);
    chk("reset_be", {28'h0, io_byte_enable}, 32'h0);
    io_rst_n = 1'b1;
    @(negedge io_clk);
    chk("reset_cmd_ready", {31'h0, cmd_ready}, 32'h1);

    for (int i = 0; i < 9; i++) begin
      run_txn($sformatf("v%0d", i), vecs[i].wr, vecs[i].addr, vecs[i].be, vecs[i].wd,
              vecs[i].rdy, vecs[i].stray, vecs[i].rd, vecs[i].hold, vecs[i].late,
              vecs[i].exp_err, vecs[i].exp_rd, vecs[i].exp_cyc);
    end

    // Asynchronous reset in the middle of WAIT drops the transaction.
    @(negedge io_clk);
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_address = 32'hE0000050;
    cmd_byte_enable = 4'hF; cmd_write_data = 32'h0;
    @(negedge io_clk);
    cmd_valid = 1'b0;
    @(negedge io_clk);
    chk("rst_mid_busy_before", {31'h0, busy}, 32'h1);
    #2 io_rst_n = 1'b0;
    #1;
    chk("rst_mid_async", {27'h0, busy, rsp_valid, io_addr_strobe, io_read_strobe, io_write_strobe}, 32'h0);
    chk("rst_mid_addr", io_address, 32'h0);
    @(negedge io_clk);
    io_rst_n = 1'b1;
    @(negedge io_clk);
    chk("rst_mid_cmd_ready", {31'h0, cmd_ready}, 32'h1);
    rsp_seen = 0;
    for (int c = 0; c < 12; c++) begin
      io_ready = c[0];
      io_read_data = $urandom;
      @(negedge io_clk);
      if (rsp_valid || busy) rsp_seen++;
    end
    io_ready = 1'b0;
    chk("rst_mid_no_rsp", rsp_seen, 0);

    for (int i = 0; i < 30; i++) begin
      r_wr  = 1'($urandom);
      r_rdy = int'($urandom_range(0, T + 3));
      r_rd  = $urandom;
      model(r_wr, r_rdy, r_rd, m_err, m_data, m_cyc);
      run_txn($sformatf("r%0d", i), r_wr, $urandom, 4'($urandom), $urandom,
              r_rdy, int'($urandom_range(0, 1)), r_rd, int'($urandom_range(0, 3)),
              1'($urandom), m_err, m_data, m_cyc);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
